// File: rtl/add_pkg.sv
// Shared defaults and types for the registered carry-lookahead adder.
package add_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_GROUP = 4;
    localparam int NGROUPS   = DEF_WIDTH / DEF_GROUP;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } add_flags_t;

endpackage

// File: rtl/add_32_cla_group.sv
// GROUP-bit carry-lookahead cell: local sum plus group propagate/generate
// for the second-level lookahead in the top.
module cla_group
    import add_pkg::*;
#(
    parameter int GROUP = DEF_GROUP
) (
    input  logic [GROUP:1] a,
    input  logic [GROUP:1] b,
    input  logic           cin,
    output logic [GROUP:1] sum,
    output logic           p,
    output logic           g
);

    logic [GROUP:1]   gi;
    logic [GROUP:1]   pi;
    logic [GROUP-1:0] cy;
    logic             term;
    logic             prod;

    assign gi = a & b;
    assign pi = a ^ b;

    // Each carry is a flat sum-of-products over lower bits, not a ripple chain.
    always_comb begin
        cy    = '0;
        cy[0] = cin;
        g     = 1'b0;
        term  = 1'b0;
        prod  = 1'b0;
        for (int i = 1; i <= GROUP; i++) begin
            term = gi[i];
            prod = pi[i];
            for (int j = i - 1; j >= 1; j--) begin
                term = term | (prod & gi[j]);
                prod = prod & pi[j];
            end
            if (i < GROUP) cy[i] = term | (prod & cin);
            else           g     = term;
        end
    end

    assign p   = &pi;
    assign sum = pi ^ cy;

endmodule

// File: rtl/add_32.sv
// Registered WIDTH-bit adder: {cout,c} = a + b + cin with signed-overflow
// and zero flags, one cycle latency, async active-high reset.
module add_32
    import add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [WIDTH:1] a,
    input  logic [WIDTH:1] b,
    input  logic           cin,
    output logic [WIDTH:1] c,
    output logic           cout,
    output logic           ovf,
    output logic           zero
);

    localparam int NG = WIDTH / GROUP;

    logic [NG-1:0]  gp;
    logic [NG-1:0]  gg;
    logic [NG:0]    gc;
    logic [WIDTH:1] sum;
    logic           term;
    logic           prod;
    add_flags_t     flags_d;
    add_flags_t     flags_q;

    genvar k;
    generate
        for (k = 0; k < NG; k++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a   (a[k*GROUP+GROUP:k*GROUP+1]),
                .b   (b[k*GROUP+GROUP:k*GROUP+1]),
                .cin (gc[k]),
                .sum (sum[k*GROUP+GROUP:k*GROUP+1]),
                .p   (gp[k]),
                .g   (gg[k])
            );
        end
    endgenerate

    // Second-level lookahead: gc[k] is the carry into group k, gc[NG] is cout.
    always_comb begin
        gc    = '0;
        gc[0] = cin;
        term  = 1'b0;
        prod  = 1'b0;
        for (int m = 1; m <= NG; m++) begin
            term = gg[m-1];
            prod = gp[m-1];
            for (int j = m - 2; j >= 0; j--) begin
                term = term | (prod & gg[j]);
                prod = prod & gp[j];
            end
            gc[m] = term | (prod & cin);
        end
    end

    always_comb begin
        flags_d      = '0;
        flags_d.cout = gc[NG];
        flags_d.ovf  = (a[WIDTH] == b[WIDTH]) && (sum[WIDTH] != a[WIDTH]);
        flags_d.zero = (sum == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c       <= '0;
            flags_q <= '0;
        end else begin
            c       <= sum;
            flags_q <= flags_d;
        end
    end

    assign cout = flags_q.cout;
    assign ovf  = flags_q.ovf;
    assign zero = flags_q.zero;

endmodule

// File: tb/tb_add_32.sv
// Table-driven and random check of add_32 against a 33-bit reference sum,
// with a scoreboard queue covering the one-cycle latency.
module tb_add_32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, c;
    logic        cin, cout, ovf, zero;

    always #5 clk = ~clk;

    add_32 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .c    (c),
        .cout (cout),
        .ovf  (ovf),
        .zero (zero)
    );

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] c;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t tbl[11];
    vec_t sb[$];
    vec_t rz;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(string tag, logic [31:0] va, logic [31:0] vb, logic vcin,
                                logic [31:0] vc, logic vcout, logic vovf, logic vzero);
        vec_t v;
        v.tag = tag; v.a = va; v.b = vb; v.cin = vcin;
        v.c = vc; v.cout = vcout; v.ovf = vovf; v.zero = vzero;
        return v;
    endfunction

    function automatic vec_t model(logic [31:0] va, logic [31:0] vb, logic vcin);
        logic [32:0] s;
        s = {1'b0, va} + {1'b0, vb} + {32'd0, vcin};
        return mk("rand", va, vb, vcin, s[31:0], s[32],
                  (va[31] == vb[31]) && (s[31] != va[31]), s[31:0] == 32'd0);
    endfunction

    task automatic check(input string name, input vec_t e);
        n_vec++;
        if ({c, cout, ovf, zero} !== {e.c, e.cout, e.ovf, e.zero}) begin
            n_err++;
            $display("FAIL %s: got c=%h cout=%b ovf=%b zero=%b, want c=%h cout=%b ovf=%b zero=%b",
                     name, c, cout, ovf, zero, e.c, e.cout, e.ovf, e.zero);
        end
    endtask

    // Check the result of the previous drive, then drive the next vector.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, e);
        end
        a = v.a; b = v.b; cin = v.cin;
        sb.push_back(v);
    endtask

    task automatic flush();
        vec_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, e);
        end
    endtask

    initial begin
        tbl[0]  = mk("ones_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        tbl[1]  = mk("pos_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        tbl[2]  = mk("wrap_zero",   32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        tbl[3]  = mk("sub_5_3",     32'h00000005, 32'hFFFFFFFC, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk("max_case",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk("zero_zero",   32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk("neg_ovf_cy",  32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
        tbl[7]  = mk("mixed",       32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk("grp_carry",   32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk("long_carry",  32'h0FFFFFFF, 32'h00000000, 1'b1, 32'h10000000, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk("sub_neg",     32'h00000003, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        rz      = mk("rst",         32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset held with all-ones inputs: outputs stay clear across edges.
        rst = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
        #1 check("rst_async", rz);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold", rz);
        end
        rst = 1'b0;
        sb.push_back(mk("first_edge", a, b, cin, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));

        for (int i = 0; i < 11; i++) step(tbl[i]);

        // Inputs wiggling after the edge must not reach the registered outputs.
        step(tbl[7]);
        @(posedge clk);
        #2 a = 32'hDEADBEEF; b = 32'h0BADF00D; cin = 1'b1;
        #1 check("glitch", sb[0]);
        flush();

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1 check("rst_mid", rz);
                #1 rst = 1'b0;
                sb.delete();
                @(negedge clk);
                check("rst_mid_hold", rz);
                sb.push_back(model(a, b, cin));
            end
            step(model($urandom, $urandom, 1'($urandom_range(1, 0))));
        end
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
